// File: rtl/shift_in_reg.sv
// -----------------------------------------------------------------------------
// shift_in_reg
//   Serial-in / parallel-out shift register. Bits enter at the MSB and move
//   toward the LSB, so after Width shifts the first bit received sits at
//   bit 0. The UART receiver feeds it one sampled line bit per bit period and
//   reads the whole frame from parallel_output.
//
// Parameters
//   Width      : number of register bits (>= 1)
//   ResetValue : fill value loaded into every bit on reset
//
// Ports
//   clk             in   clock, all state changes on the rising edge
//   rst             in   synchronous active-low reset, overrides enable
//   enable          in   one shift per rising edge while high
//   serial_in       in   bit inserted at the MSB on a shift
//   serial_out      out  current bit 0, the bit the next shift discards
//   parallel_output out  current register contents
// -----------------------------------------------------------------------------
module shift_in_reg #(
  parameter int unsigned Width      = 8,
  parameter logic        ResetValue = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [Width-1:0] parallel_output
);

  if (Width < 1) begin : g_width_check
    $error("shift_in_reg: Width must be at least 1");
  end

  logic [Width-1:0] reg_q;
  logic [Width-1:0] reg_d;
  logic [Width-1:0] shifted;

  // A one-bit register has no lower slice to carry along; the new bit simply
  // replaces the old one.
  if (Width == 1) begin : g_shift_single
    assign shifted = serial_in;
  end else begin : g_shift_multi
    assign shifted = {serial_in, reg_q[Width-1:1]};
  end

  always_comb begin
    reg_d = reg_q;
    if (enable) begin
      reg_d = shifted;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_q <= {Width{ResetValue}};
    end else begin
      reg_q <= reg_d;
    end
  end

  assign parallel_output = reg_q;
  assign serial_out      = reg_q[0];

endmodule

// File: tb/tb_shift_in_reg.sv
// -----------------------------------------------------------------------------
// tb_shift_in_reg
//   Directed bench for shift_in_reg. Several instances with different
//   parameters share the same stimulus; each scenario resets all of them and
//   then checks only the instance it targets. Inputs change 1 ns after a
//   rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_shift_in_reg;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic serial_in;

  int checks   = 0;
  int failures = 0;

  logic        so_w11_r1, so_w11_r0, so_w10, so_w8, so_w4, so_w1;
  logic [10:0] po_w11_r1, po_w11_r0;
  logic [9:0]  po_w10;
  logic [7:0]  po_w8;
  logic [3:0]  po_w4;
  logic [0:0]  po_w1;

  always #5 clk = ~clk;

  shift_in_reg #(.Width(11), .ResetValue(1'b1)) u_w11_r1 (
    .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in),
    .serial_out(so_w11_r1), .parallel_output(po_w11_r1));

  shift_in_reg #(.Width(11), .ResetValue(1'b0)) u_w11_r0 (
    .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in),
    .serial_out(so_w11_r0), .parallel_output(po_w11_r0));

  shift_in_reg #(.Width(10), .ResetValue(1'b1)) u_w10 (
    .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in),
    .serial_out(so_w10), .parallel_output(po_w10));

  shift_in_reg #(.Width(8), .ResetValue(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in),
    .serial_out(so_w8), .parallel_output(po_w8));

  shift_in_reg #(.Width(4), .ResetValue(1'b0)) u_w4 (
    .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in),
    .serial_out(so_w4), .parallel_output(po_w4));

  shift_in_reg #(.Width(1), .ResetValue(1'b0)) u_w1 (
    .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in),
    .serial_out(so_w1), .parallel_output(po_w1));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One edge with rst low; enable/serial_in are held at the given values so
  // reset priority over a pending shift is exercised.
  task automatic do_reset(input logic en, input logic bit_in);
    rst       = 1'b0;
    enable    = en;
    serial_in = bit_in;
    @(posedge clk);
    #1;
    rst    = 1'b1;
    enable = 1'b0;
  endtask

  task automatic shift(input logic bit_in);
    serial_in = bit_in;
    enable    = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  task automatic hold(input int edges);
    enable = 1'b0;
    for (int i = 0; i < edges; i++) begin
      serial_in = ~serial_in;
      @(posedge clk);
      #1;
    end
  endtask

  // Frame bits in arrival order: start, 0xA5 LSB-first, stop.
  logic frame_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  // 0x3C delivered oldest-first (bit 0 first).
  logic load_bits  [8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  // Width=4 stream: 1,1,0,1 then zeros; expected bit 0 after edges 4..8.
  logic w4_bits    [8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic w4_so_exp  [5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0] w4_po_exp [5] = '{4'b1011, 4'b0101, 4'b0010, 4'b0001, 4'b0000};

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    serial_in = 1'b0;
    @(posedge clk);
    #1;

    // Reset fill, both fill values.
    do_reset(1'b0, 1'b0);
    check("w11_r1_fill", 32'(po_w11_r1), 32'h7FF);
    check("w11_r1_so",   32'(so_w11_r1), 32'h1);
    check("w11_r0_fill", 32'(po_w11_r0), 32'h000);
    check("w11_r0_so",   32'(so_w11_r0), 32'h0);

    // UART frame capture.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) shift(frame_bits[i]);
    check("uart_frame",  32'(po_w10), 32'h34A);
    check("uart_data",   32'(po_w10[8:1]), 32'hA5);
    check("uart_so",     32'(so_w10), 32'h0);

    // Enable gating.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) shift(load_bits[i]);
    check("load_3c",     32'(po_w8), 32'h3C);
    hold(5);
    check("hold_3c",     32'(po_w8), 32'h3C);
    shift(1'b1);
    check("shift_9e",    32'(po_w8), 32'h9E);
    check("shift_9e_so", 32'(so_w8), 32'h0);

    // serial_out stream on Width=4.
    do_reset(1'b0, 1'b0);
    check("w4_reset",    32'(po_w4), 32'h0);
    for (int i = 0; i < 8; i++) begin
      shift(w4_bits[i]);
      if (i >= 3) begin
        check($sformatf("w4_so_e%0d", i + 1), 32'(so_w4), 32'(w4_so_exp[i-3]));
        check($sformatf("w4_po_e%0d", i + 1), 32'(po_w4), 32'(w4_po_exp[i-3]));
      end
    end

    // Reset priority in the middle of a sequence.
    do_reset(1'b0, 1'b0);
    check("w8_fill",     32'(po_w8), 32'hFF);
    for (int i = 0; i < 3; i++) shift(1'b0);
    check("w8_three0",   32'(po_w8), 32'h1F);
    do_reset(1'b1, 1'b0);
    check("w8_rst_prio", 32'(po_w8), 32'hFF);
    shift(1'b0);
    check("w8_after_rst", 32'(po_w8), 32'h7F);

    // Width=1 corner.
    do_reset(1'b0, 1'b0);
    check("w1_reset",    32'(po_w1), 32'h0);
    shift(1'b1);
    check("w1_shift1",   32'(po_w1), 32'h1);
    check("w1_so1",      32'(so_w1), 32'h1);
    shift(1'b0);
    check("w1_shift0",   32'(po_w1), 32'h0);
    shift(1'b1);
    do_reset(1'b1, 1'b1);
    check("w1_rst_prio", 32'(po_w1), 32'h0);
    check("w1_rst_so",   32'(so_w1), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
